// File: rtl/aes_inv_sub_bytes_ctrl_if.sv
// Valid/ready handshake bundle for the column-serial inverse SubBytes block.
// "slave" is the block itself; "master" is the requester/consumer side.
interface aes_inv_sub_bytes_ctrl_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] out_data_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o
    );
endinterface

// File: rtl/aes_inv_sub_bytes_ctrl.sv
// Inverse SubBytes over a 128-bit AES state, one 32-bit column per cycle
// through four shared inverse S-boxes.

module aes_inv_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        return gf_mul(x127, x127);
    endfunction

    logic [7:0] pre;

    // Inverse affine transform first, then the field inverse.
    always_comb begin
        pre  = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
        dout = gf_inv(pre);
    end
endmodule

// state | meaning
// IDLE  | no block held, ready for a new state
// RUN   | column cnt of the input register goes through the S-boxes this cycle
// DONE  | full result in output register, waiting for the consumer
module aes_inv_sub_bytes_ctrl (
    input  logic                      clk,
    input  logic                      nreset,
    aes_inv_sub_bytes_ctrl_if.slave   bus,
    output logic                      busy_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [1:0]   cnt;
    logic [127:0] in_reg;
    logic [127:0] out_reg;
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [6:0]   col_base;

    assign col_base = {cnt, 5'b00000};
    assign col_in   = in_reg[col_base +: 32];

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .din  (col_in[8*g +: 8]),
            .dout (col_out[8*g +: 8])
        );
    end

    assign bus.in_ready_o  = (state == IDLE) || ((state == DONE) && bus.out_ready_i);
    assign bus.out_valid_o = (state == DONE);
    assign bus.out_data_o  = out_reg;
    assign busy_o          = (state != IDLE);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            in_reg  <= '0;
            out_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        in_reg <= bus.in_data_i;
                        cnt    <= 2'd0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    out_reg[col_base +: 32] <= col_out;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= DONE;
                end
                DONE: begin
                    // Output and next input can transfer on the same edge.
                    if (bus.out_ready_i) begin
                        if (bus.in_valid_i) begin
                            in_reg <= bus.in_data_i;
                            cnt    <= 2'd0;
                            state  <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_sub_bytes_ctrl.sv
// Directed and randomized-handshake checks of aes_inv_sub_bytes_ctrl against
// a log/antilog-table reference of the FIPS-197 inverse S-box.
module tb_aes_inv_sub_bytes_ctrl;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic [7:0] inv_tab [256];

    aes_inv_sub_bytes_ctrl_if bus ();

    aes_inv_sub_bytes_ctrl dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        int n;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        #1;
        n = 0;
        while (!bus.in_ready_o && n < 50) begin
            step();
            n++;
        end
        chk("send_ready", 128'(bus.in_ready_o), 128'(1));
        step();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid_o && lat < 50) begin
            step();
            lat++;
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int s);
        logic [15:0] w;
        w = {a, a} << s;
        return w[15:8];
    endfunction

    task automatic build_ref;
        logic [7:0] exp_t [256];
        int         log_t [256];
        logic [7:0] x;
        logic [7:0] iv;
        logic [7:0] fw;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = xt(x) ^ x;
        end
        for (int a = 0; a < 256; a++) begin
            iv = (a == 0) ? 8'h00 : exp_t[(255 - log_t[a]) % 255];
            fw = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
            inv_tab[fw] = 8'(a);
        end
    endtask

    function automatic logic [127:0] inv_blk(input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[d[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] blk(input int n, input int base);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(n * 16 + k + base);
        return r;
    endfunction

    initial begin
        int lat;
        int sent;
        int rcvd;
        logic vld;
        logic inf;
        logic outf;
        logic [127:0] snap;
        logic [127:0] exp_b;
        logic [127:0] q [$];
        logic [127:0] b [5];

        build_ref();
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b1;

        // Reset values, then first transfer on the first edge after release
        #2;
        chk("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
        chk("rst_busy",      128'(busy),            128'(0));
        chk("rst_in_ready",  128'(bus.in_ready_o),  128'(1));
        chk("rst_out_data",  bus.out_data_o,        128'(0));
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = {16{8'h63}};
        #20;
        nreset = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        chk("t1_busy",      128'(busy),            128'(1));
        chk("t1_in_ready",  128'(bus.in_ready_o),  128'(0));
        chk("t1_valid_e0",  128'(bus.out_valid_o), 128'(0));
        for (int i = 1; i < 4; i++) begin
            step();
            chk("t1_valid_early", 128'(bus.out_valid_o), 128'(0));
        end
        step();
        chk("t1_valid_e4", 128'(bus.out_valid_o), 128'(1));
        chk("t1_data",     bus.out_data_o,        128'(0));
        step();
        chk("t1_pulse_end", 128'(bus.out_valid_o), 128'(0));
        chk("t1_idle_busy", 128'(busy),            128'(0));

        // Backpressure: result held for 10 cycles
        bus.out_ready_i = 1'b0;
        send(128'(0));
        wait_valid(lat);
        chk("t2_latency", 128'(lat), 128'(4));
        for (int i = 0; i < 10; i++) begin
            chk("t2_hold_valid", 128'(bus.out_valid_o), 128'(1));
            chk("t2_hold_data",  bus.out_data_o,        {16{8'h52}});
            chk("t2_in_ready",   128'(bus.in_ready_o),  128'(0));
            step();
        end
        bus.out_ready_i = 1'b1;
        #1;
        chk("t2_ready_done", 128'(bus.in_ready_o), 128'(1));
        step();
        chk("t2_released", 128'(bus.out_valid_o), 128'(0));
        chk("t2_idle",     128'(busy),            128'(0));

        // Byte positions preserved; input noise during RUN ignored
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = {4{32'h63017C16}};
        step();
        for (int i = 0; i < 3; i++) begin
            bus.in_data_i = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = {$urandom, $urandom, $urandom, $urandom};
        step();
        chk("t3_valid", 128'(bus.out_valid_o), 128'(1));
        chk("t3_data",  bus.out_data_o,        {4{32'h000901FF}});
        step();
        chk("t3_idle",  128'(busy),            128'(0));

        // Back-to-back: one block every 5 cycles
        for (int k = 0; k < 4; k++) b[k] = blk(k, 8'h3a);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = b[0];
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) bus.in_data_i = b[k];
            else       bus.in_valid_i = 1'b0;
            for (int e = 1; e < 4; e++) begin
                step();
                chk("t4_busy_run", 128'(busy),            128'(1));
                chk("t4_no_valid", 128'(bus.out_valid_o), 128'(0));
            end
            step();
            chk("t4_valid",    128'(bus.out_valid_o), 128'(1));
            chk("t4_data",     bus.out_data_o,        inv_blk(b[k-1]));
            chk("t4_in_ready", 128'(bus.in_ready_o),  128'(1));
            step();
            chk("t4_busy_next", 128'(busy), 128'(k < 4));
        end

        // Reset pulse while cnt = 2 discards the block
        send(blk(1, 8'h11));
        step();
        step();
        #1 nreset = 1'b0;
        #1;
        chk("t5_rst_valid",    128'(bus.out_valid_o), 128'(0));
        chk("t5_rst_busy",     128'(busy),            128'(0));
        chk("t5_rst_in_ready", 128'(bus.in_ready_o),  128'(1));
        chk("t5_rst_data",     bus.out_data_o,        128'(0));
        #2 nreset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t5_no_valid", 128'(bus.out_valid_o), 128'(0));
        end
        send({4{32'h63017C16}});
        wait_valid(lat);
        chk("t5_latency", 128'(lat),       128'(4));
        chk("t5_data",    bus.out_data_o,  {4{32'h000901FF}});
        step();

        // All 256 byte values with random gaps and backpressure
        sent = 0;
        rcvd = 0;
        vld  = 1'b0;
        for (int cyc = 0; cyc < 3000 && rcvd < 16; cyc++) begin
            if (!vld && sent < 16 && $urandom_range(0, 2) != 0) vld = 1'b1;
            bus.in_valid_i  = vld;
            bus.in_data_i   = vld ? blk(sent, 0) : {$urandom, $urandom, $urandom, $urandom};
            bus.out_ready_i = 1'($urandom_range(0, 1));
            #1;
            inf  = bus.in_valid_i && bus.in_ready_o;
            outf = bus.out_valid_o && bus.out_ready_i;
            snap = bus.out_data_o;
            step();
            if (outf) begin
                if (q.size() > 0) exp_b = q.pop_front();
                else              exp_b = ~snap;
                chk("t6_block", snap, exp_b);
                rcvd++;
            end
            if (inf) begin
                q.push_back(inv_blk(blk(sent, 0)));
                sent++;
                vld = 1'b0;
            end
        end
        bus.in_valid_i = 1'b0;
        chk("t6_received", 128'(rcvd),     128'(16));
        chk("t6_drained",  128'(q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
